// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte FIFO between the UART RX shift FSM and the
// APB register file. Tracks occupancy, flags dropped bytes with a sticky
// overrun bit, and optionally raises a fill-level interrupt.
//
// Optional feature macro: UART_RX_FIFO_THRESH_EN (fill-level interrupt).
//
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   RXen                     receiver enable, gates pushes only
//   fifo_en                  1 = DEPTH entries, 0 = single holding register
//   rx_data_i, done_rx       byte and its one-cycle valid strobe
//   rd_en                    one-cycle pop strobe
//   flush_i                  synchronous clear of contents and flags
//   clr_overrun_i            clears overrun_o
//   thresh_i                 fill threshold (macro only)
//   rd_data_o                registered read data
//   ptr_addr_rd_o/_wr_o      read / write pointers
//   count_o                  occupancy 0..DEPTH
//   empty_o, full_o          decoded from registered count_o
//   overrun_o                sticky byte-loss flag
//   thresh_irq_o             fill-level interrupt level (macro only)
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          RXen,
    input  logic          fifo_en,
    input  logic [DW-1:0] rx_data_i,
    input  logic          done_rx,
    input  logic          rd_en,
    input  logic          flush_i,
    input  logic          clr_overrun_i,
    input  logic [AW-1:0] thresh_i,
    output logic [DW-1:0] rd_data_o,
    output logic [AW-1:0] ptr_addr_rd_o,
    output logic [AW-1:0] ptr_addr_wr_o,
    output logic [AW:0]   count_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          overrun_o,
    output logic          thresh_irq_o
);

    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [CW-1:0] cap;
    logic          push_req;
    logic          pop_ok;
    logic          push_ok;
    logic          ovr_evt;
    logic [CW-1:0] count_nxt;

    // Capacity collapses to one entry in holding-register mode
    assign cap     = fifo_en ? CW'(DEPTH) : CW'(1);
    assign empty_o = (count_o == '0);
    assign full_o  = (count_o == cap);

    // Push/pop qualification; a same-cycle pop frees the slot for a push when full
    always_comb begin
        push_req  = done_rx & RXen & ~flush_i;
        pop_ok    = rd_en & ~empty_o & ~flush_i;
        push_ok   = push_req & (~full_o | pop_ok);
        ovr_evt   = push_req & full_o & ~pop_ok;
        count_nxt = count_o;
        if (flush_i) begin
            count_nxt = '0;
        end else if (push_ok && !pop_ok) begin
            count_nxt = count_o + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_nxt = count_o - CW'(1);
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[ptr_addr_wr_o] <= rx_data_i;
        end
    end

    // Pointers, occupancy, read data and overrun flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_o     <= '0;
            ptr_addr_rd_o <= '0;
            ptr_addr_wr_o <= '0;
            count_o       <= '0;
            overrun_o     <= 1'b0;
        end else if (flush_i) begin
            ptr_addr_rd_o <= '0;
            ptr_addr_wr_o <= '0;
            count_o       <= '0;
            overrun_o     <= 1'b0;
        end else begin
            count_o <= count_nxt;
            if (pop_ok) begin
                rd_data_o     <= mem[ptr_addr_rd_o];
                ptr_addr_rd_o <= ptr_addr_rd_o + AW'(1);
            end
            if (push_ok) begin
                ptr_addr_wr_o <= ptr_addr_wr_o + AW'(1);
            end
            // A new loss event beats a same-cycle clear
            if (ovr_evt) begin
                overrun_o <= 1'b1;
            end else if (clr_overrun_i) begin
                overrun_o <= 1'b0;
            end
        end
    end

`ifdef UART_RX_FIFO_THRESH_EN
    // Level interrupt: high while post-update occupancy exceeds the threshold
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            thresh_irq_o <= 1'b0;
        end else begin
            thresh_irq_o <= (count_nxt > CW'(thresh_i));
        end
    end
`else
    logic unused_thresh;
    assign unused_thresh = ^thresh_i;
    assign thresh_irq_o  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed steps plus randomized
// traffic, compared every cycle against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 32;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       RXen;
    logic       fifo_en;
    logic [7:0] rx_data_i;
    logic       done_rx;
    logic       rd_en;
    logic       flush_i;
    logic       clr_overrun_i;
    logic [4:0] thresh_i;
    logic [7:0] rd_data_o;
    logic [4:0] ptr_addr_rd_o;
    logic [4:0] ptr_addr_wr_o;
    logic [5:0] count_o;
    logic       empty_o;
    logic       full_o;
    logic       overrun_o;
    logic       thresh_irq_o;

    uart_rx_fifo dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .RXen          (RXen),
        .fifo_en       (fifo_en),
        .rx_data_i     (rx_data_i),
        .done_rx       (done_rx),
        .rd_en         (rd_en),
        .flush_i       (flush_i),
        .clr_overrun_i (clr_overrun_i),
        .thresh_i      (thresh_i),
        .rd_data_o     (rd_data_o),
        .ptr_addr_rd_o (ptr_addr_rd_o),
        .ptr_addr_wr_o (ptr_addr_wr_o),
        .count_o       (count_o),
        .empty_o       (empty_o),
        .full_o        (full_o),
        .overrun_o     (overrun_o),
        .thresh_irq_o  (thresh_irq_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] q[$];
    logic [7:0] m_rd;
    int         m_wp;
    int         m_rp;
    bit         m_ovr;
    bit         m_irq;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        int cap;
        cap = fifo_en ? DEPTH : 1;
        check({ctx, "/rd_data"}, 32'(rd_data_o), 32'(m_rd));
        check({ctx, "/rd_ptr"},  32'(ptr_addr_rd_o), 32'(m_rp));
        check({ctx, "/wr_ptr"},  32'(ptr_addr_wr_o), 32'(m_wp));
        check({ctx, "/count"},   32'(count_o), 32'(q.size()));
        check({ctx, "/empty"},   32'(empty_o), 32'(q.size() == 0));
        check({ctx, "/full"},    32'(full_o), 32'(q.size() == cap));
        check({ctx, "/overrun"}, 32'(overrun_o), 32'(m_ovr));
        check({ctx, "/irq"},     32'(thresh_irq_o), 32'(m_irq));
    endtask

    task automatic model_reset();
        q.delete();
        m_rd  = 8'h00;
        m_wp  = 0;
        m_rp  = 0;
        m_ovr = 1'b0;
        m_irq = 1'b0;
    endtask

    // One clock cycle with the given strobes, then model update and full check
    task automatic step(input string ctx, input bit done, input logic [7:0] data,
                        input bit rd, input bit flush, input bit clr);
        bit push, pop, was_full;
        int cap;
        done_rx       = done;
        rx_data_i     = data;
        rd_en         = rd;
        flush_i       = flush;
        clr_overrun_i = clr;
        cap      = fifo_en ? DEPTH : 1;
        was_full = (q.size() == cap);
        push     = done && RXen && !flush;
        pop      = rd && (q.size() != 0) && !flush;
        @(posedge clk_i);
        if (flush) begin
            q.delete();
            m_wp  = 0;
            m_rp  = 0;
            m_ovr = 1'b0;
        end else begin
            if (pop) begin
                m_rd = q.pop_front();
                m_rp = (m_rp + 1) % DEPTH;
            end
            if (clr) m_ovr = 1'b0;
            if (push) begin
                if (!was_full || pop) begin
                    q.push_back(data);
                    m_wp = (m_wp + 1) % DEPTH;
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end
`ifdef UART_RX_FIFO_THRESH_EN
        m_irq = (q.size() > int'(thresh_i));
`else
        m_irq = 1'b0;
`endif
        #1;
        check_all(ctx);
    endtask

    initial begin
        rst_ni        = 1'b0;
        RXen          = 1'b1;
        fifo_en       = 1'b1;
        rx_data_i     = 8'h00;
        done_rx       = 1'b0;
        rd_en         = 1'b0;
        flush_i       = 1'b0;
        clr_overrun_i = 1'b0;
        thresh_i      = 5'd3;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check_all("reset");
        rst_ni = 1'b1;

        // Single byte round trip
        step("push_a5", 1, 8'hA5, 0, 0, 0);
        step("pop_a5",  0, 8'h00, 1, 0, 0);
        check("a5_value", 32'(rd_data_o), 32'hA5);
        step("pop_empty", 0, 8'h00, 1, 0, 0);

        // Fill to DEPTH, overflow, drain in order
        for (int i = 0; i < DEPTH; i++) step("fill", 1, 8'(i), 0, 0, 0);
        step("overflow", 1, 8'hFF, 0, 0, 0);
        check("overflow_full", 32'(full_o), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            step("drain", 0, 8'h00, 1, 0, 0);
            check("drain_order", 32'(rd_data_o), 32'(i));
        end
        step("clr_ovr", 0, 8'h00, 0, 0, 1);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) step("refill", 1, 8'(8'h40 + i), 0, 0, 0);
        step("full_push_pop", 1, 8'hEE, 1, 0, 0);
        check("full_pp_count", 32'(count_o), 32'd32);
        step("full_push_pop2", 1, 8'hED, 1, 0, 0);

        // Clear racing a new overrun: flag must stay set
        step("ovr_evt", 1, 8'h99, 0, 0, 0);
        step("clr_vs_ovr", 1, 8'h98, 0, 0, 1);

        // RXen low drops silently, pops continue
        RXen = 1'b0;
        step("rxen_off_push", 1, 8'h77, 0, 0, 0);
        step("rxen_off_pop",  0, 8'h00, 1, 0, 0);
        RXen = 1'b1;

        // Holding-register mode
        step("flush_pre_mode", 0, 8'h00, 0, 1, 0);
        fifo_en = 1'b0;
        step("hold_push1", 1, 8'h11, 0, 0, 0);
        step("hold_push2", 1, 8'h22, 0, 0, 0);
        step("hold_pop",   0, 8'h00, 1, 0, 0);
        check("hold_value", 32'(rd_data_o), 32'h11);
        step("hold_flush", 0, 8'h00, 0, 1, 0);
        fifo_en = 1'b1;

        // Threshold behaviour around thresh_i = 3
        thresh_i = 5'd3;
        for (int i = 0; i < 4; i++) step("thr_push", 1, 8'(8'h30 + i), 0, 0, 0);
        step("thr_pop", 0, 8'h00, 1, 0, 0);

        // Flush beats same-cycle push and pop
        step("pre_flush_clear", 0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 10; i++) step("ten", 1, 8'(8'hC0 + i), 0, 0, 0);
        step("flush_with_push", 1, 8'h55, 1, 1, 0);
        step("pop_after_flush", 0, 8'h00, 1, 0, 0);

        // Randomized traffic: push-heavy then pop-heavy
        for (int i = 0; i < 600; i++) begin
            bit d, r, f, c;
            if (i % 25 == 0) thresh_i = 5'($urandom_range(0, 31));
            RXen = ($urandom_range(0, 7) != 0);
            d = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            r = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 99) == 0);
            c = ($urandom_range(0, 7) == 0);
            step("rand", d, 8'($urandom), r, f, c);
        end
        RXen = 1'b1;

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 5; i++) step("burst", 1, 8'(8'h60 + i), 0, 0, 0);
        done_rx = 1'b1;
        #3;
        rst_ni = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        done_rx = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        step("post_rst_push", 1, 8'h3C, 0, 0, 0);
        step("post_rst_pop",  0, 8'h00, 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side FIFO for the UART: buffers bytes delivered by the RX shift FSM and hands them to the APB interface on read strobes. It is the counterpart of the transmit FIFO and sits between the RX FSM and the APB register file. It tracks occupancy, raises a sticky overrun flag on loss, and optionally raises a programmable fill-level interrupt.

## Interface
- `DEPTH`, default 32: entries; power of two.
- `AW`, default 5: pointer width, log2(DEPTH).
- `DW`, default 8: data width.

Ports (clock and reset first):
- `clk_i` in 1: sole clock, rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `RXen` in 1: receiver enable; gates pushes only.
- `fifo_en` in 1: 1 = full DEPTH buffering; 0 = single-entry holding register mode.
- `rx_data_i` in DW: byte from RX FSM.
- `done_rx` in 1: one-cycle strobe, `rx_data_i` valid.
- `rd_en` in 1: one-cycle pop strobe from APB.
- `flush_i` in 1: synchronous clear of contents and flags.
- `clr_overrun_i` in 1: clears `overrun_o`.
- `thresh_i` in AW: fill threshold (used only with macro).
- `rd_data_o` out DW: registered read data.
- `ptr_addr_rd_o` out AW: read pointer.
- `ptr_addr_wr_o` out AW: write pointer.
- `count_o` out AW+1: occupancy, 0..DEPTH.
- `empty_o` out 1: count_o == 0.
- `full_o` out 1: count_o == cap (cap = DEPTH if fifo_en, else 1).
- `overrun_o` out 1: sticky byte-loss flag.
- `thresh_irq_o` out 1: fill-level interrupt (macro only).

## Operation
- Storage: DEPTH x DW circular array; pointers increment mod DEPTH (DEPTH-1 -> 0 wrap); no comparison-based full detection, `count_o` is authoritative.
- Push = `done_rx & RXen & !flush_i`. Accepted if `!full_o`, or if a pop is accepted the same cycle. Accepted push writes `mem[ptr_addr_wr_o]` and increments write pointer.
- Push while full with no same-cycle pop: byte dropped, pointers unchanged, `overrun_o` <= 1.
- Pop = `rd_en & !empty_o & !flush_i`: `rd_data_o` <= `mem[ptr_addr_rd_o]`, read pointer increments. Pop while empty: ignored, `rd_data_o` holds, no flag.
- Simultaneous push and pop with `count_o` == 0: pop ignored, push accepted (no bypass); count -> 1.
- Simultaneous accepted push and pop otherwise: count unchanged, both pointers advance.
- `RXen` = 0: pushes ignored silently (no overrun); pops continue, allowing drain.
- `fifo_en` = 0: cap = 1; a second byte before pop sets overrun. Changing `fifo_en` while occupancy > 1 is illegal; software flushes first.
- `flush_i` (highest priority): pointers, count, `overrun_o`, `thresh_irq_o` -> 0; `rd_data_o` holds; array contents need not clear.
- `clr_overrun_i` clears `overrun_o`; a same-cycle new overrun event wins (flag stays 1).

## Timing
- Reset (async assert, release sync to `clk_i`): `rd_data_o`=0, both pointers 0, `count_o`=0, `empty_o`=1, `full_o`=0, `overrun_o`=0, `thresh_irq_o`=0. Reset mid-operation discards all contents.
- Write latency: byte pushed at edge N is poppable from edge N+1 (`empty_o` low after N).
- Read latency: `rd_en` sampled at edge N -> `rd_data_o` valid after N, held until next accepted pop.
- `empty_o`, `full_o` decoded combinationally from registered `count_o`; flags and pointers all update on the same edge.
- `overrun_o` rises the edge after the dropped `done_rx`.

## Configuration
- `UART_RX_FIFO_THRESH_EN` defined: `thresh_irq_o` is a register, set when post-update count >= `thresh_i` + 1, cleared when post-update count <= `thresh_i`; level, not pulse.
- Undefined: `thresh_i` unused, `thresh_irq_o` tied 0; no threshold logic.

## Test plan
- Reset, push 0xA5 via `done_rx`, pop -> `rd_data_o`=0xA5 one cycle after `rd_en`, count 1->0, `empty_o`=1.
- Push 32 bytes 0x00..0x1F, 33rd byte 0xFF -> `full_o`=1, `overrun_o`=1, then 32 pops return 0x00..0x1F in order; write pointer wrapped to 0.
- Full FIFO, `done_rx` and `rd_en` same cycle -> no overrun, count stays 32, pointers both advance by 1.
- `fifo_en`=0: push 0x11, push 0x22 -> `full_o`=1 after first, `overrun_o`=1, pop returns 0x11.
- 10 bytes queued, `flush_i` with `done_rx` same cycle -> count 0, `overrun_o`=0, pop ignored; assert `rst_ni` low mid-burst -> all outputs at reset values immediately.
- With macro, `thresh_i`=3: 4th push raises `thresh_irq_o`, next pop lowers it; without macro `thresh_irq_o` stays 0.
